// File: rtl/vga_frame_bank_if.sv
// vga_frame_bank_if
//   Bundles the VGA read port, the vertical sync input and the system-side
//   write/commit handshake of vga_frame_bank.
//   master : the surroundings (VGA pointers, sync counters, system logic)
//   slave  : the frame bank itself
//   Signals:
//     MemAddrIN  - read address from the VGA pointers
//     MemDataOut - registered read data (1-cycle latency)
//     VSync      - vertical sync, active-low pulse
//     WrAddr/WrData/WrValid/WrReady - shadow-bank write handshake
//     Commit     - single-cycle request to publish the shadow bank
//     Pending    - commit requested and not yet finished
//     CommitDone - one-cycle pulse when publish and copy-back are complete
interface vga_frame_bank_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] MemAddrIN;
  logic [DATA_W-1:0] MemDataOut;
  logic              VSync;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrValid;
  logic              WrReady;
  logic              Commit;
  logic              Pending;
  logic              CommitDone;

  modport master (
    output MemAddrIN, VSync, WrAddr, WrData, WrValid, Commit,
    input  MemDataOut, WrReady, Pending, CommitDone
  );

  modport slave (
    input  MemAddrIN, VSync, WrAddr, WrData, WrValid, Commit,
    output MemDataOut, WrReady, Pending, CommitDone
  );
endinterface

// File: rtl/vga_frame_bank.sv
// vga_frame_bank
//   Double-buffered video data memory. The VGA pointers read the displayed
//   bank; the system writes into the shadow bank. A commit request swaps the
//   banks at the next VSync falling edge, then copies the newly displayed
//   bank back into the new shadow so further edits start from the picture
//   currently on screen.
//   Ports:
//     CLK   - clock, all logic on the rising edge
//     RESET - asynchronous active-low reset
//     bus   - vga_frame_bank_if slave modport (read port, VSync, write and
//             commit handshake, status)
module vga_frame_bank #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  vga_frame_bank_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } state_t;

  state_t            state_reg;
  logic              disp_sel_reg;     // 0: bank A displayed, 1: bank B displayed
  logic [ADDR_W-1:0] cnt_reg;
  logic              vs_q_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              commit_done_reg;

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];

  logic vs_fall;
  logic wr_fire;
  logic copy_en;

  assign vs_fall = vs_q_reg & ~bus.VSync;
  assign wr_fire = (state_reg == IDLE) & bus.WrValid;
  assign copy_en = (state_reg == COPY);

  // One register pair per address. Writes and copy-back only ever target
  // the shadow bank; the displayed bank is read-only while it is on screen.
  // A write and a copy can never coincide because writes are only taken in
  // IDLE and copies only happen in COPY.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] a_reg;
      logic [DATA_W-1:0] b_reg;
      logic              sel_wr;
      logic              sel_cp;

      assign sel_wr = wr_fire && (bus.WrAddr == ADDR_W'(gi));
      assign sel_cp = copy_en && (cnt_reg == ADDR_W'(gi));

      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (disp_sel_reg) begin
          // B displayed, A is the shadow
          if (sel_wr)
            a_reg <= bus.WrData;
          else if (sel_cp)
            a_reg <= b_reg;
        end else begin
          // A displayed, B is the shadow
          if (sel_wr)
            b_reg <= bus.WrData;
          else if (sel_cp)
            b_reg <= a_reg;
        end
      end

      assign bank_a[gi] = a_reg;
      assign bank_b[gi] = b_reg;
    end
  endgenerate

  // Control FSM, VSync edge history and the registered read port.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg       <= IDLE;
      disp_sel_reg    <= 1'b0;
      cnt_reg         <= '0;
      vs_q_reg        <= 1'b1;
      mem_data_reg    <= '0;
      commit_done_reg <= 1'b0;
    end else begin
      vs_q_reg        <= bus.VSync;
      commit_done_reg <= 1'b0;
      mem_data_reg    <= disp_sel_reg ? bank_b[bus.MemAddrIN] : bank_a[bus.MemAddrIN];

      case (state_reg)
        IDLE: begin
          // A VSync edge in the commit cycle is deliberately not used:
          // the swap always waits for a later edge.
          if (bus.Commit)
            state_reg <= PENDING;
        end
        PENDING: begin
          if (vs_fall) begin
            disp_sel_reg <= ~disp_sel_reg;
            cnt_reg      <= '0;
            state_reg    <= COPY;
          end
        end
        COPY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            commit_done_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.MemDataOut = mem_data_reg;
  assign bus.CommitDone = commit_done_reg;
  assign bus.Pending    = (state_reg != IDLE);
  assign bus.WrReady    = (state_reg == IDLE);

endmodule
